// File: rtl/parity_pkg.sv
// Shared parity constants and helpers for parity generators and checkers.
package parity_pkg;

  localparam int unsigned DEFAULT_PARITY_WIDTH = 3;

  // Narrower words zero-extend into the argument without changing the result.
  function automatic logic calc_even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parity_xor_tree.sv
// Balanced combinational XOR reduction of a WIDTH-bit word.
module parity_xor_tree #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  if (WIDTH == 1) begin : g_leaf
    assign parity = data[0];
  end else begin : g_split
    localparam int unsigned LoWidth = WIDTH / 2;
    localparam int unsigned HiWidth = WIDTH - LoWidth;

    logic lo_parity;
    logic hi_parity;

    parity_xor_tree #(
      .WIDTH(LoWidth)
    ) u_lo (
      .data  (data[LoWidth-1:0]),
      .parity(lo_parity)
    );

    parity_xor_tree #(
      .WIDTH(HiWidth)
    ) u_hi (
      .data  (data[WIDTH-1:LoWidth]),
      .parity(hi_parity)
    );

    assign parity = lo_parity ^ hi_parity;
  end

endmodule

// File: rtl/parity_generator.sv
// Word parity (combinational and registered) plus parity accumulated over
// in_last-delimited frames.
module parity_generator
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_PARITY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] m,
  output logic             even_parity_bit,
  output logic             odd_parity_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             q_valid,
  output logic             q_even,
  output logic             q_odd,
  output logic             frame_valid,
  output logic             frame_even,
  output logic             frame_odd
);

  logic word_parity;
  logic acc_q;
  logic acc_d;
  logic frame_parity;

  parity_xor_tree #(
    .WIDTH(WIDTH)
  ) u_xor_tree (
    .data  (m),
    .parity(word_parity)
  );

  assign even_parity_bit = word_parity;
  assign odd_parity_bit  = ~word_parity;

  // Closing word folds into the reported parity; the accumulator restarts at 0.
  always_comb begin
    frame_parity = acc_q ^ word_parity;
    acc_d        = acc_q;
    if (in_valid) begin
      acc_d = in_last ? 1'b0 : frame_parity;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid     <= 1'b0;
      q_even      <= 1'b0;
      frame_valid <= 1'b0;
      frame_even  <= 1'b0;
      acc_q       <= 1'b0;
    end else begin
      q_valid     <= in_valid;
      frame_valid <= in_valid & in_last;
      acc_q       <= acc_d;
      if (in_valid) begin
        q_even <= word_parity;
        if (in_last) begin
          frame_even <= frame_parity;
        end
      end
    end
  end

  assign q_odd     = ~q_even;
  assign frame_odd = ~frame_even;

endmodule

// File: tb/tb_parity_generator.sv
// Directed bench for parity_generator: vector table for the combinational path
// and hand-written sequences for the registered and frame paths.
module tb_parity_generator;

  logic       clk;
  logic       rst;
  logic [2:0] m;
  logic       even_parity_bit;
  logic       odd_parity_bit;
  logic       in_valid;
  logic       in_last;
  logic       q_valid;
  logic       q_even;
  logic       q_odd;
  logic       frame_valid;
  logic       frame_even;
  logic       frame_odd;

  logic clk_run;
  int   n_vec;
  int   n_err;

  parity_generator #(
    .WIDTH(3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m              (m),
    .even_parity_bit(even_parity_bit),
    .odd_parity_bit (odd_parity_bit),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .q_valid        (q_valid),
    .q_even         (q_even),
    .q_odd          (q_odd),
    .frame_valid    (frame_valid),
    .frame_even     (frame_even),
    .frame_odd      (frame_odd)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic [2:0] m;
    logic       even;
  } vec_t;

  vec_t table_v[8];

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic [2:0] w);
    in_valid = v;
    in_last  = l;
    m        = w;
  endtask

  initial begin
    logic [2:0] tm;
    logic       exp_even;

    n_vec   = 0;
    n_err   = 0;
    clk_run = 1'b0;
    rst     = 1'b1;
    drive(1'b0, 1'b0, 3'b000);

    table_v[0] = '{3'b000, 1'b0};
    table_v[1] = '{3'b001, 1'b1};
    table_v[2] = '{3'b010, 1'b1};
    table_v[3] = '{3'b011, 1'b0};
    table_v[4] = '{3'b100, 1'b1};
    table_v[5] = '{3'b101, 1'b0};
    table_v[6] = '{3'b110, 1'b0};
    table_v[7] = '{3'b111, 1'b1};

    #1;
    check("rst_q_valid", q_valid, 1'b0);
    check("rst_q_even", q_even, 1'b0);
    check("rst_q_odd", q_odd, 1'b1);
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_frame_even", frame_even, 1'b0);
    check("rst_frame_odd", frame_odd, 1'b1);

    // Combinational sweep while reset is held and no clock runs.
    for (int i = 0; i < 8; i++) begin
      m = table_v[i].m;
      #1;
      check($sformatf("sweep_even_%03b", table_v[i].m), even_parity_bit, table_v[i].even);
      check($sformatf("sweep_odd_%03b", table_v[i].m), odd_parity_bit, ~table_v[i].even);
    end

    rst = 1'b0;
    // m[0]/m[1]/m[2] toggle every 5/15/30 ns, clock idle.
    for (int k = 0; k < 13; k++) begin
      tm[0] = 1'((k / 1) % 2);
      tm[1] = 1'((k / 3) % 2);
      tm[2] = 1'((k / 6) % 2);
      m = tm;
      exp_even = tm[0] ^ tm[1] ^ tm[2];
      #1;
      check($sformatf("toggle_even_t%0d", k), even_parity_bit, exp_even);
      n_vec++;
      if (odd_parity_bit === even_parity_bit) begin
        n_err++;
        $display("FAIL toggle_odd_t%0d: odd %b equals even %b", k, odd_parity_bit,
                 even_parity_bit);
      end
      #4;
    end
    check("idle_q_valid", q_valid, 1'b0);

    // Registered word path.
    clk_run = 1'b1;
    step();
    drive(1'b1, 1'b0, 3'b011);
    step();
    check("reg1_q_valid", q_valid, 1'b1);
    check("reg1_q_even", q_even, 1'b0);
    check("reg1_q_odd", q_odd, 1'b1);
    drive(1'b1, 1'b0, 3'b111);
    step();
    check("reg2_q_valid", q_valid, 1'b1);
    check("reg2_q_even", q_even, 1'b1);
    drive(1'b0, 1'b0, 3'b000);
    step();
    check("reg3_q_valid", q_valid, 1'b0);
    check("reg3_q_even_hold", q_even, 1'b1);
    check("reg3_q_odd_hold", q_odd, 1'b0);

    // Clear the accumulator left over from the registered-path words.
    rst = 1'b1;
    #2;
    rst = 1'b0;

    // Frame 001, 011, 100 -> four ones.
    step();
    drive(1'b1, 1'b0, 3'b001);
    step();
    check("f1w1_frame_valid", frame_valid, 1'b0);
    drive(1'b1, 1'b0, 3'b011);
    step();
    drive(1'b0, 1'b0, 3'b000);
    step();
    check("f1gap_frame_valid", frame_valid, 1'b0);
    drive(1'b1, 1'b1, 3'b100);
    step();
    check("f1_frame_valid", frame_valid, 1'b1);
    check("f1_frame_even", frame_even, 1'b0);
    check("f1_frame_odd", frame_odd, 1'b1);
    drive(1'b1, 1'b1, 3'b010);
    step();
    check("f2_frame_valid", frame_valid, 1'b1);
    check("f2_frame_even", frame_even, 1'b1);
    check("f2_frame_odd", frame_odd, 1'b0);
    drive(1'b0, 1'b0, 3'b000);
    step();
    check("f2_pulse_end", frame_valid, 1'b0);
    check("f2_frame_even_hold", frame_even, 1'b1);

    // Async reset mid-frame: 001, 010 then reset between edges.
    drive(1'b1, 1'b0, 3'b001);
    step();
    drive(1'b1, 1'b0, 3'b010);
    step();
    drive(1'b0, 1'b0, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_q_valid", q_valid, 1'b0);
    check("mrst_q_even", q_even, 1'b0);
    check("mrst_q_odd", q_odd, 1'b1);
    check("mrst_frame_valid", frame_valid, 1'b0);
    check("mrst_frame_even", frame_even, 1'b0);
    check("mrst_frame_odd", frame_odd, 1'b1);
    #1;
    rst = 1'b0;
    step();
    drive(1'b1, 1'b1, 3'b001);
    step();
    check("mrst_new_frame_valid", frame_valid, 1'b1);
    check("mrst_new_frame_even", frame_even, 1'b1);

    // Odd partial accumulation before reset must not leak into the next frame.
    drive(1'b1, 1'b0, 3'b001);
    step();
    drive(1'b0, 1'b0, 3'b000);
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    drive(1'b1, 1'b1, 3'b010);
    step();
    check("discard_frame_valid", frame_valid, 1'b1);
    check("discard_frame_even", frame_even, 1'b1);
    drive(1'b0, 1'b0, 3'b000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
